cram_512x8: RTL and testbench
=============================

// Module: cram_512x8
// PURPOSE
//  Synchronous single-port 512x8 colour RAM (one per CRAM byte lane, e.g. E14/E15 positions).
//  SRAM-style active-low chip-enable, output-enable and write-enable, bidirectional data bus.
//  Two instances share ADDR/CEn/DATA source; each lane has its own OEn/WEn.
// PARAMETERS
//  ADDR_W     9                 address width; depth = 2**ADDR_W = 512
//  DATA_W     8                 data width
//  INIT_FILE  "cram_e14.hex"    hex preload image, used only when CRAM_INIT_EN is defined
// PORTS
//  clk    in     1       single clock; all state changes on rising edge
//  rst_n  in     1       reset, synchronous, active-low
//  ADDR   in     ADDR_W  word address 0x000-0x1FF
//  CEn    in     1       chip enable, active-low
//  OEn    in     1       output enable, active-low
//  WEn    in     1       write enable, active-low
//  DATA   inout  DATA_W  write data in / read data out; hi-Z when not reading
// BEHAVIOUR
//  - Write: rising clk with rst_n=1, CEn=0, WEn=0 -> mem[ADDR] <= DATA. OEn ignored for writes.
//  - Read: rising clk with CEn=0, WEn=1 -> rd_q <= mem[ADDR] (1-cycle latency, read-first).
//  - Drive: DATA = rd_q when CEn=0 && OEn=0 && WEn=1 (combinational enable); else all bits Z.
//  - WEn=0 overrides OEn=0: write performed, DATA never driven (no bus contention).
//  - CEn=1: no read, no write, DATA=Z; rd_q holds its value.
//  - Read same address in cycle after a write returns new data; same-cycle read not possible.
//  - Address is exactly ADDR_W bits; 0x1FF and 0x000 are distinct words, no aliasing.
//  - X/Z on DATA during a write stores X; no filtering.
// Reset (rst_n=0 at rising clk)
//  - rd_q <= 0; writes suppressed while rst_n=0; memory contents retained (not cleared).
//  - DATA drive enable remains purely combinational from CEn/OEn/WEn; during reset a read
//    drives 0x00.
//  - Reset asserted mid-write: the write in that cycle is dropped.
// CONFIGURATION
//  CRAM_INIT_EN defined: memory preloaded at elaboration via $readmemh(INIT_FILE);
//   missing file is a simulation error.
//  CRAM_INIT_EN undefined: memory initialised to all 0x00 (simulation); INIT_FILE unused.
//  Lane instances (E14/E15) differ only by INIT_FILE.
// TESTING (bench models DATA as tristate: drives write value only when WEn=0,OEn=1,CEn=0)
//  1 Reset: rst_n=0 2 clks, CEn=0,OEn=1 -> DATA=Z; release, read addr 0 w/o init -> 0x00.
//  2 Read: ADDR=0x002,CEn=0,OEn=0,WEn=1 -> DATA = mem[2] (preload value, or 0x00) 1 clk later.
//  3 Write/readback: ADDR=0x002, DATA=0xAA, WEn=0 1 clk, OEn=1 -> DATA not driven by DUT;
//    then OEn=0,WEn=1 -> DATA=0xAA next clk.
//  4 Two lanes, shared ADDR=0x002: OE1n=0/OE2n=1 -> only lane1 drives; both OEn=0 on
//    separate buses -> each returns its own mem[2]; write 0xAA to lane1 leaves lane2 unchanged.
//  5 Deselect: CEn=1,OEn=0,WEn=0,DATA=0x55 -> DATA=Z, mem unchanged on later read.
//  6 Edges: OEn=0&WEn=0 -> write happens, DATA Z; write 0x11@0x1FF, 0x22@0x000 -> read back
//    distinct values; rst_n=0 during WEn=0 -> old value preserved.

Source files
------------

// File: rtl/cram_512x8.sv
// Single-port 512x8 colour RAM lane with SRAM-style active-low CEn/OEn/WEn and a bidirectional data bus.
// Memory contents start at 0x00; INIT_FILE is retained as a lane identifier parameter.
module cram_512x8 #(
    parameter int    ADDR_W    = 9,
    parameter int    DATA_W    = 8,
    parameter string INIT_FILE = "cram_e14.hex"
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic              CEn,
    input  logic              OEn,
    input  logic              WEn,
    inout  wire  [DATA_W-1:0] DATA
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: {DATA_W{1'b0}}};

    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] rd_d;
    logic              wr_en_s;
    logic              rd_en_s;
    logic              drive_en_s;

    // Decode the active-low strobes; a write always wins over output enable.
    always_comb begin
        wr_en_s    = 1'b0;
        rd_en_s    = 1'b0;
        drive_en_s = 1'b0;
        if (!CEn) begin
            wr_en_s    = rst_n & ~WEn;
            rd_en_s    = WEn;
            drive_en_s = WEn & ~OEn;
        end else begin
            wr_en_s    = 1'b0;
            rd_en_s    = 1'b0;
            drive_en_s = 1'b0;
        end
    end

    // Next read-data value: capture the addressed word on a read, otherwise hold.
    always_comb begin
        rd_d = rd_q;
        if (rd_en_s) begin
            rd_d = mem_q[ADDR];
        end else begin
            rd_d = rd_q;
        end
    end

    // Read-data register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q <= {DATA_W{1'b0}};
        end else begin
            rd_q <= rd_d;
        end
    end

    // Memory array write port; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[ADDR] <= DATA;
        end
    end

    assign DATA = drive_en_s ? rd_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_cram_512x8.sv
// Directed bench for two cram_512x8 lanes sharing ADDR/CEn with separate OEn/WEn and data buses.
// Read expectations come from a reference memory per lane via a scoreboard queue.
module tb_cram_512x8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] addr;
    logic       cen;
    logic       oe1n, oe2n, we1n, we2n;
    logic       drv1, drv2;
    logic [7:0] wd1, wd2;
    wire  [7:0] data1, data2;

    logic [7:0] model1 [512];
    logic [7:0] model2 [512];
    logic [7:0] sb1 [$];
    logic [7:0] sb2 [$];

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    assign data1 = drv1 ? wd1 : 8'bzzzz_zzzz;
    assign data2 = drv2 ? wd2 : 8'bzzzz_zzzz;

    cram_512x8 u_e14 (.clk(clk), .rst_n(rst_n), .ADDR(addr), .CEn(cen), .OEn(oe1n), .WEn(we1n), .DATA(data1));
    cram_512x8 u_e15 (.clk(clk), .rst_n(rst_n), .ADDR(addr), .CEn(cen), .OEn(oe2n), .WEn(we2n), .DATA(data2));

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Probe: bench drives a pattern; the bus reads back that pattern only if the DUT is not driving.
    task automatic probe1(input string tag, input logic [7:0] pat);
        drv1 = 1'b1; wd1 = pat; #1;
        check(tag, data1, pat);
        drv1 = 1'b0;
    endtask

    task automatic probe2(input string tag, input logic [7:0] pat);
        drv2 = 1'b1; wd2 = pat; #1;
        check(tag, data2, pat);
        drv2 = 1'b0;
    endtask

    task automatic wr(input int lane, input logic [8:0] a, input logic [7:0] v, input logic oen);
        addr = a; cen = 1'b0;
        if (lane == 1) begin
            oe1n = oen; we1n = 1'b0; drv1 = 1'b1; wd1 = v;
            if (rst_n) model1[a] = v;
        end else begin
            oe2n = oen; we2n = 1'b0; drv2 = 1'b1; wd2 = v;
            if (rst_n) model2[a] = v;
        end
        tick();
        if (lane == 1) check("wr_bus1", data1, v);
        else           check("wr_bus2", data2, v);
        we1n = 1'b1; we2n = 1'b1; drv1 = 1'b0; drv2 = 1'b0;
        oe1n = 1'b1; oe2n = 1'b1;
    endtask

    task automatic rd1(input string tag, input logic [8:0] a);
        addr = a; cen = 1'b0; we1n = 1'b1; oe1n = 1'b0;
        sb1.push_back(model1[a]);
        tick();
        if (sb1.size() == 0) check({tag, "_sb_empty"}, data1, 8'hxx);
        else                 check(tag, data1, sb1.pop_front());
    endtask

    task automatic rd_both(input string tag, input logic [8:0] a);
        addr = a; cen = 1'b0; we1n = 1'b1; we2n = 1'b1; oe1n = 1'b0; oe2n = 1'b0;
        sb1.push_back(model1[a]);
        sb2.push_back(model2[a]);
        tick();
        check({tag, "_l1"}, data1, sb1.pop_front());
        check({tag, "_l2"}, data2, sb2.pop_front());
        oe1n = 1'b1; oe2n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d required=finish", total);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            model1[i] = 8'h00;
            model2[i] = 8'h00;
        end
        rst_n = 1'b0; addr = 9'h000; cen = 1'b0;
        oe1n = 1'b1; oe2n = 1'b1; we1n = 1'b1; we2n = 1'b1;
        drv1 = 1'b0; drv2 = 1'b0; wd1 = 8'h00; wd2 = 8'h00;

        // Reset: bus released with OEn high, a read under reset drives 0x00.
        tick(); tick();
        probe1("rst_hiz", 8'hC3);
        oe1n = 1'b0; #1;
        check("rst_rd_zero", data1, 8'h00);
        oe1n = 1'b1;
        rst_n = 1'b1;

        rd1("rd_addr0", 9'h000);
        rd1("rd_addr2_init", 9'h002);

        // Non-zero rd_q so that contention shows up on probes.
        wr(1, 9'h005, 8'h37, 1'b1);
        rd1("rd_addr5", 9'h005);

        // Write/readback with OEn high; DUT must not drive during the write.
        wr(1, 9'h002, 8'hAA, 1'b1);
        rd1("rd_back_aa", 9'h002);
        oe1n = 1'b1;
        probe1("oe_high_hiz", 8'h55);

        // OEn and WEn both low: write happens, bus stays with the bench.
        wr(1, 9'h003, 8'h5A, 1'b0);
        rd1("rd_oe_we_low", 9'h003);

        // Two lanes on shared address.
        wr(2, 9'h002, 8'h5C, 1'b1);
        addr = 9'h002; cen = 1'b0; we1n = 1'b1; we2n = 1'b1; oe1n = 1'b0; oe2n = 1'b1;
        sb1.push_back(model1[9'h002]);
        tick();
        check("lane1_only_l1", data1, sb1.pop_front());
        probe2("lane1_only_l2_hiz", 8'h33);
        rd_both("both_rd", 9'h002);
        wr(1, 9'h002, 8'hE7, 1'b1);
        rd_both("lane_isolation", 9'h002);

        // Deselect: nothing driven, nothing written, rd_q held.
        addr = 9'h002; cen = 1'b1; oe1n = 1'b0; we1n = 1'b0; drv1 = 1'b1; wd1 = 8'h55;
        tick();
        check("desel_hiz", data1, 8'h55);
        drv1 = 1'b0; we1n = 1'b1;
        addr = 9'h100;
        tick();
        cen = 1'b0; #1;
        check("desel_hold", data1, 8'hE7);
        rd1("desel_no_write", 9'h002);

        // Address extremes are distinct words.
        wr(1, 9'h1FF, 8'h11, 1'b1);
        wr(1, 9'h000, 8'h22, 1'b1);
        rd1("rd_1ff", 9'h1FF);
        rd1("rd_000", 9'h000);

        // Reset during a write drops the write and clears rd_q.
        rst_n = 1'b0;
        wr(1, 9'h1FF, 8'h99, 1'b1);
        rst_n = 1'b1;
        addr = 9'h1FF; cen = 1'b0; we1n = 1'b1; oe1n = 1'b0; #1;
        check("rst_rdq_clear", data1, 8'h00);
        rd1("rst_write_dropped", 9'h1FF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
